// File: rtl/draw_image_scaled.sv
// draw_image_scaled: maps the current raster x/y onto a stored image in RAM,
// replicating each image pixel SCALE times in both directions, and turns the
// returned byte (grey or RGB332) into 24-bit colour with a fixed latency of
// RD_LAT+2 cycles. Samples outside the image window get BG_RGB.
`timescale 1ns/1ps
module draw_image_scaled #(
  parameter int                HRES         = 640,
  parameter int                VRES         = 480,
  parameter int                IMG_WIDTH    = 400,
  parameter int                IMG_HEIGHT   = 433,
  parameter int                ADDR_W       = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDRESS = 'h10,
  parameter int                X0           = 0,
  parameter int                Y0           = 0,
  parameter int                SCALE        = 1,
  parameter int                RD_LAT       = 1,
  parameter logic [23:0]       BG_RGB       = 24'hFFFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              active,
  input  logic              mode,
  input  logic [7:0]        q,
  output logic [ADDR_W-1:0] rdaddress,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  output logic              pix_valid
);

  // SCALE is a power of two, so the pixel-to-image divide is a shift.
  localparam int SH     = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  // Control stages ahead of the output register: address reg + RAM latency.
  localparam int STG    = RD_LAT + 1;
  // Window end, clipped to the visible raster; columns/rows past the screen
  // edge never reach the RAM.
  localparam int X_WIN  = X0 + IMG_WIDTH * SCALE;
  localparam int Y_WIN  = Y0 + IMG_HEIGHT * SCALE;
  localparam int X_END  = (X_WIN < HRES) ? X_WIN : HRES;
  localparam int Y_END  = (Y_WIN < VRES) ? Y_WIN : VRES;

  typedef struct packed {
    logic act;
    logic win;
    logic mode;
  } ctl_t;

  ctl_t [STG-1:0]    pipe_q, pipe_d;
  logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
  logic [7:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic              pix_valid_q, pix_valid_d;

  int                xi, yi, col, row;
  logic              in_win;
  logic [31:0]       addr_sum;
  ctl_t              last;

  // Window test, address generation and the control delay line.
  always_comb begin
    xi       = int'(x);
    yi       = int'(y);
    in_win   = (xi >= X0) && (xi < X_END) && (yi >= Y0) && (yi < Y_END);
    col      = (xi - X0) >>> SH;
    row      = (yi - Y0) >>> SH;
    addr_sum = 32'(BASE_ADDRESS) + 32'(row * IMG_WIDTH) + 32'(col);
    rdaddress_d = rdaddress_q;
    if (active && in_win) rdaddress_d = addr_sum[ADDR_W-1:0];
    pipe_d[0] = '{act: active, win: in_win, mode: mode};
    for (int i = 1; i < STG; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Colour formatting for the sample whose RAM data is arriving now.
  always_comb begin
    last        = pipe_q[STG-1];
    red_d       = 8'h00;
    green_d     = 8'h00;
    blue_d      = 8'h00;
    pix_valid_d = last.act;
    if (last.act) begin
      if (!last.win) begin
        red_d   = BG_RGB[23:16];
        green_d = BG_RGB[15:8];
        blue_d  = BG_RGB[7:0];
      end else if (last.mode) begin
        red_d   = {q[7:5], q[7:5], q[7:6]};
        green_d = {q[4:2], q[4:2], q[4:3]};
        blue_d  = {q[1:0], q[1:0], q[1:0], q[1:0]};
      end else begin
        red_d   = q;
        green_d = q;
        blue_d  = q;
      end
    end
  end

  // State registers; reset empties the delay line so the first L cycles
  // after release come out as blank, invalid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q      <= '0;
      rdaddress_q <= BASE_ADDRESS;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      pix_valid_q <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      rdaddress_q <= rdaddress_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rdaddress = rdaddress_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_draw_image_scaled.sv
// Directed bench for draw_image_scaled: three configurations (defaults,
// SCALE=2 with offset window, RD_LAT=3) share the raster inputs. Each RAM
// model returns the low byte of the address it was given, so expected
// colours follow directly from the hand-computed addresses.
`timescale 1ns/1ps
module tb_draw_image_scaled;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] x, y;
  logic active, mode;

  logic [17:0] a0, a1, a2;
  logic [7:0]  q0, q1, q2, r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic        pv0, pv1, pv2;
  logic [17:0] r2a, r2b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  draw_image_scaled u0 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .mode(mode),
    .q(q0), .rdaddress(a0), .red(r0), .green(g0), .blue(b0), .pix_valid(pv0));

  draw_image_scaled #(.SCALE(2), .X0(100), .Y0(20)) u1 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .mode(mode),
    .q(q1), .rdaddress(a1), .red(r1), .green(g1), .blue(b1), .pix_valid(pv1));

  draw_image_scaled #(.RD_LAT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active), .mode(mode),
    .q(q2), .rdaddress(a2), .red(r2), .green(g2), .blue(b2), .pix_valid(pv2));

  // RAM models: data = address[7:0], with the configured read latency.
  always @(posedge clk) begin
    q0  <= a0[7:0];
    q1  <= a1[7:0];
    r2a <= a2;
    r2b <= r2a;
    q2  <= r2b[7:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; x = 10'd5; y = 10'd2; active = 1'b1; mode = 1'b0;
    // reset state
    step(); step();
    chk("rst_red", 32'(r0), 32'h00);
    chk("rst_grn", 32'(g0), 32'h00);
    chk("rst_blu", 32'(b0), 32'h00);
    chk("rst_pv", 32'(pv0), 32'h0);
    chk("rst_addr0", 32'(a0), 32'h10);
    chk("rst_addr2", 32'(a2), 32'h10);

    // x=5,y=2 in defaults -> 2*400+5+16 = 0x335
    rst_n = 1'b1;
    step();
    chk("e1_addr0", 32'(a0), 32'h335);
    chk("e1_addr1_held", 32'(a1), 32'h10);
    step();
    chk("e2_pv0_blank", 32'(pv0), 32'h0);
    step();
    chk("e3_red0", 32'(r0), 32'h35);
    chk("e3_grn0", 32'(g0), 32'h35);
    chk("e3_blu0", 32'(b0), 32'h35);
    chk("e3_pv0", 32'(pv0), 32'h1);
    chk("e3_bg1_red", 32'(r1), 32'hFF);
    chk("e3_bg1_pv", 32'(pv1), 32'h1);
    chk("e3_pv2_blank", 32'(pv2), 32'h0);
    step();
    chk("e4_pv2_blank", 32'(pv2), 32'h0);
    step();
    chk("e5_red2", 32'(r2), 32'h35);
    chk("e5_pv2", 32'(pv2), 32'h1);

    // RGB332: x=211,y=0 -> addr 0xE3 -> q=E3
    x = 10'd211; y = 10'd0; mode = 1'b1;
    repeat (3) step();
    chk("rgb_red", 32'(r0), 32'hFF);
    chk("rgb_grn", 32'(g0), 32'h00);
    chk("rgb_blu", 32'(b0), 32'hFF);
    // grey: x=74 -> addr 0x5A; the old format stays until L cycles later
    x = 10'd74; mode = 1'b0;
    step(); step();
    chk("mode_hold_grn", 32'(g0), 32'h00);
    step();
    chk("grey_red", 32'(r0), 32'h5A);
    chk("grey_grn", 32'(g0), 32'h5A);
    chk("grey_blu", 32'(b0), 32'h5A);

    // x=400 is the first column past the image
    x = 10'd400;
    step();
    chk("edge_addr_held", 32'(a0), 32'h5A);
    step(); step();
    chk("edge_red", 32'(r0), 32'hFF);
    chk("edge_grn", 32'(g0), 32'hFF);
    chk("edge_blu", 32'(b0), 32'hFF);
    chk("edge_pv", 32'(pv0), 32'h1);

    // SCALE=2, X0=100, Y0=20: (103,25) -> row2 col1 -> 0x331
    x = 10'd103; y = 10'd25;
    step();
    chk("s2_addr_103", 32'(a1), 32'h331);
    x = 10'd104;
    step();
    chk("s2_addr_104", 32'(a1), 32'h332);
    x = 10'd99;
    step();
    chk("s2_addr_99_held", 32'(a1), 32'h332);
    chk("s2_red_103", 32'(r1), 32'h31);
    step();
    chk("s2_red_104", 32'(r1), 32'h32);
    step();
    chk("s2_bg_red", 32'(r1), 32'hFF);
    chk("s2_bg_grn", 32'(g1), 32'hFF);
    chk("s2_bg_blu", 32'(b1), 32'hFF);

    // single inactive sample inside a run
    x = 10'd5; y = 10'd2;
    repeat (3) step();
    active = 1'b0;
    step();
    active = 1'b1;
    step();
    chk("gap_pre_pv", 32'(pv0), 32'h1);
    step();
    chk("gap_pv", 32'(pv0), 32'h0);
    chk("gap_red", 32'(r0), 32'h00);
    chk("gap_blu", 32'(b0), 32'h00);
    step();
    chk("gap_post_pv", 32'(pv0), 32'h1);
    chk("gap_post_red", 32'(r0), 32'h35);

    // mid-line asynchronous reset
    step();
    rst_n = 1'b0;
    #1;
    chk("async_red", 32'(r0), 32'h00);
    chk("async_pv0", 32'(pv0), 32'h0);
    chk("async_addr0", 32'(a0), 32'h10);
    chk("async_addr2", 32'(a2), 32'h10);
    chk("async_pv2", 32'(pv2), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_e1_pv0", 32'(pv0), 32'h0);
    step();
    chk("rel_e2_pv0", 32'(pv0), 32'h0);
    chk("rel_e2_red0", 32'(r0), 32'h00);
    step();
    chk("rel_e3_pv0", 32'(pv0), 32'h1);
    chk("rel_e3_red0", 32'(r0), 32'h35);
    chk("rel_e3_pv2", 32'(pv2), 32'h0);
    step();
    chk("rel_e4_pv2", 32'(pv2), 32'h0);
    step();
    chk("rel_e5_pv2", 32'(pv2), 32'h1);
    chk("rel_e5_red2", 32'(r2), 32'h35);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/draw_image_scaled.md
DRAW_IMAGE_SCALED -- requirements
Module: draw_image_scaled

Interface
REQ-001 SHALL have parameter HRES, default 640, horizontal display resolution in pixels.
REQ-002 SHALL have parameter VRES, default 480, vertical display resolution in lines.
REQ-003 SHALL have parameter IMG_WIDTH, default 400, stored image width in pixels.
REQ-004 SHALL have parameter IMG_HEIGHT, default 433, stored image height in lines.
REQ-005 SHALL have parameter BASE_ADDRESS, default 18'h10, RAM address of image pixel (0,0).
REQ-006 SHALL have parameter ADDR_W, default 18, RAM address width.
REQ-007 SHALL have parameters X0 and Y0, default 0, screen position of the image top-left corner.
REQ-008 SHALL have parameter SCALE, default 1, legal values 1, 2 or 4, integer pixel replication factor.
REQ-009 SHALL have parameter RD_LAT, default 1, legal values 1 to 3, RAM read latency in cycles.
REQ-010 SHALL have parameter BG_RGB, default 24'hFFFFFF, colour outside the image window.
REQ-011 SHALL have port clk, input, 1 bit, pixel clock; all logic is clocked on its rising edge.
REQ-012 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-013 SHALL have port x, input, 10 bits, current pixel column.
REQ-014 SHALL have port y, input, 10 bits, current pixel row.
REQ-015 SHALL have port active, input, 1 bit, display-enable for the current x/y.
REQ-016 SHALL have port mode, input, 1 bit, pixel format: 0 = 8-bit grey, 1 = RGB332.
REQ-017 SHALL have port q, input, 8 bits, RAM read data.
REQ-018 SHALL have port rdaddress, output, ADDR_W bits, RAM read address.
REQ-019 SHALL have ports red, green and blue, outputs, 8 bits each, pixel colour.
REQ-020 SHALL have port pix_valid, output, 1 bit, marks red/green/blue as belonging to an active pixel.

Function
REQ-021 SHALL treat a sample as in-window when X0 <= x < X0+IMG_WIDTH*SCALE and Y0 <= y < Y0+IMG_HEIGHT*SCALE; the window bounds SHALL be compared at full width with no wrap.
REQ-022 SHALL register rdaddress one cycle after sampling an in-window x,y; value = BASE_ADDRESS + row*IMG_WIDTH + col, where col = (x-X0)/SCALE and row = (y-Y0)/SCALE, computed modulo 2^ADDR_W.
REQ-023 SHALL hold rdaddress at its last value for samples that are out-of-window or have active=0.
REQ-024 SHALL carry active, the in-window flag and mode through a delay line aligned with the data, giving total latency L = RD_LAT+2 cycles from x/y sample to red/green/blue/pix_valid.
REQ-025 SHALL register q into red/green/blue at cycle L for an in-window active sample.
REQ-026 SHALL, in grey mode (mode=0), drive red = green = blue = q.
REQ-027 SHALL, in RGB332 mode (mode=1), drive red = {q[7:5],q[7:5],q[7:6]}, green = {q[4:2],q[4:2],q[4:3]}, blue = {q[1:0],q[1:0],q[1:0],q[1:0]}.
REQ-028 SHALL drive BG_RGB[23:16]/[15:8]/[7:0] onto red/green/blue at cycle L for an active, out-of-window sample.
REQ-029 SHALL drive red = green = blue = 0 and pix_valid = 0 at cycle L for an active=0 sample.
REQ-030 SHALL set pix_valid to the delayed active flag.
REQ-031 SHALL use the mode value sampled with each pixel; a mode change SHALL take effect exactly L cycles later, with no mixed-format pixel.
REQ-032 SHALL accept parameter combinations with X0+IMG_WIDTH*SCALE > HRES or Y0+IMG_HEIGHT*SCALE > VRES; those pixels are never addressed.

Reset
REQ-033 SHALL, while rst_n=0, immediately force red = green = blue = 0, pix_valid = 0, rdaddress = BASE_ADDRESS, and clear every delay-line stage.
REQ-034 SHALL, after rst_n is released mid-frame, output zeros with pix_valid=0 for exactly L cycles, then resume per REQ-021 to REQ-031 from the current x/y with no frame resync needed.

Verification
REQ-035 SHALL cover this case: defaults, active=1, x=5, y=2 -> rdaddress=18'h335 after 1 cycle; red=green=blue=q after 3 cycles; pix_valid=1.
REQ-036 SHALL cover this case: SCALE=2, X0=100, Y0=20, x=103, y=25 -> rdaddress=18'h331; x=104 -> 18'h332; x=99 -> rdaddress held, colour=BG_RGB.
REQ-037 SHALL cover this case: defaults, x=400, y=0, active=1 -> red=green=blue=8'hFF at cycle 3, rdaddress unchanged.
REQ-038 SHALL cover this case: mode=1, q=8'hE3 in-window -> red=8'hFF, green=8'h00, blue=8'hFF; mode=0, q=8'h5A -> all channels 8'h5A.
REQ-039 SHALL cover this case: active=0 for one cycle within a run -> one pixel of zeros with pix_valid=0, exactly 3 cycles later.
REQ-040 SHALL cover this case: rst_n pulsed low mid-line -> outputs and pix_valid go to 0 asynchronously and rdaddress=18'h10; after release, 3 zero cycles, then correct pixels; repeat with RD_LAT=3, which gives 5 zero cycles.
